axis_eth_loopback_64: RTL and testbench

- 64-bit AXI-stream Ethernet frame loopback stage, placed between the MAC RX FIFO output and the MAC TX FIFO input of an SFP port.
- Optionally swaps the destination and source MAC addresses in each frame, so looped frames return to the sender with valid addressing.
- Maintains frame and error counters.
- Captures one configurable byte of each frame for LED or hex-display status.
- Full line rate (one beat per clock) is required.

---
 rtl/axis_eth_pkg.sv | 30 +++
 rtl/axis_eth_if.sv | 14 +
 rtl/axis_eth_mac_swap.sv | 51 +++++
 rtl/axis_eth_loopback_64.sv | 157 +++++++++++++++
 tb/tb_axis_eth_loopback_64.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_eth_pkg.sv
// Shared constants, beat record and MAC-swap helper for the 64-bit AXI-stream Ethernet datapath.
package axis_eth_pkg;

   localparam int DATA_W               = 64;
   localparam int KEEP_W               = 8;
   localparam int MAC_DST_OFFSET       = 0;
   localparam int MAC_SRC_OFFSET       = 6;
   localparam int MAC_ETHERTYPE_OFFSET = 12;
   localparam int SWAP_KEEP_W          = MAC_ETHERTYPE_OFFSET - KEEP_W;

   typedef enum logic [1:0] {
      BEAT_FIRST  = 2'd0,
      BEAT_SECOND = 2'd1,
      BEAT_REST   = 2'd2
   } beat_idx_e;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [KEEP_W-1:0] keep;
      logic              last;
      logic              user;
   } beat_t;

   // First beat after the swap: source MAC bytes 6..11 land in 0..5, destination bytes 0..1 land in 6..7.
   function automatic logic [DATA_W-1:0] swap_first_beat(input logic [DATA_W-1:0] first,
                                                         input logic [8*SWAP_KEEP_W-1:0] next_lo);
      return {first[8*MAC_DST_OFFSET +: 16], next_lo, first[8*MAC_SRC_OFFSET +: 16]};
   endfunction

endpackage

// File: rtl/axis_eth_if.sv
// AXI-stream bundle for the 64-bit Ethernet datapath; master drives data, slave drives ready.
interface axis_eth_if;
   import axis_eth_pkg::*;

   logic [DATA_W-1:0] tdata;
   logic [KEEP_W-1:0] tkeep;
   logic              tvalid;
   logic              tready;
   logic              tlast;
   logic              tuser;

   modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
   modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_eth_mac_swap.sv
// Rewrites beats 0 and 1 of a frame so destination and source MAC addresses trade places.
module axis_eth_mac_swap
   import axis_eth_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     swap_mode,
   input  logic                     a_move,
   input  beat_idx_e                a_idx,
   input  logic                     a_last,
   input  logic [DATA_W-1:0]        a_data,
   input  logic [SWAP_KEEP_W-1:0]   next_keep_lo,
   input  logic [8*SWAP_KEEP_W-1:0] next_data_lo,
   output logic [DATA_W-1:0]        out_data
);

   logic [8*SWAP_KEEP_W-1:0] side_q, side_d;
   logic                     apply_q, apply_d;
   logic                     start_swap;

   // Beat 0 only leaves A together with the arrival of beat 1, so the next beat's low bytes are live here.
   always_comb begin
      start_swap = a_move && (a_idx == BEAT_FIRST) && !a_last && swap_mode && (&next_keep_lo);
      side_d     = side_q;
      apply_d    = apply_q;
      out_data   = a_data;
      if (start_swap) begin
         out_data = swap_first_beat(a_data, next_data_lo);
         side_d   = a_data[8*(MAC_DST_OFFSET+2) +: 8*SWAP_KEEP_W];
         apply_d  = 1'b1;
      end else if (a_idx == BEAT_SECOND) begin
         if (apply_q) begin
            out_data = {a_data[DATA_W-1:8*SWAP_KEEP_W], side_q};
         end
         if (a_move) begin
            apply_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         side_q  <= '0;
         apply_q <= 1'b0;
      end else begin
         side_q  <= side_d;
         apply_q <= apply_d;
      end
   end

endmodule

// File: rtl/axis_eth_loopback_64.sv
// Two-stage AXI-stream loopback with optional MAC swap, frame/error counters and a status byte capture.
module axis_eth_loopback_64
   import axis_eth_pkg::*;
#(
   parameter int COUNT_WIDTH    = 32,
   parameter int CAPTURE_OFFSET = 14,
   parameter bit SWAP_DEFAULT   = 1'b1
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   swap_enable,
   input  logic                   stat_clear,
   axis_eth_if.slave              input_axis,
   axis_eth_if.master             output_axis,
   output logic [COUNT_WIDTH-1:0] stat_frame_count,
   output logic [COUNT_WIDTH-1:0] stat_error_count,
   output logic [7:0]             stat_capture_byte,
   output logic                   stat_capture_valid
);

   localparam logic [3:0] CAP_BEAT = 4'(CAPTURE_OFFSET / 8);
   localparam int         CAP_LANE = CAPTURE_OFFSET % 8;

   beat_t                  a_q, a_d, b_q, b_d, in_beat;
   logic                   a_valid_q, a_valid_d, b_valid_q, b_valid_d;
   beat_idx_e              a_idx_q, a_idx_d, in_idx;
   logic [3:0]             cap_idx_q, cap_idx_d;
   logic                   swap_q, swap_d;
   logic                   rdy_q, rdy_d;
   logic [COUNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;
   logic [7:0]             cap_byte_q, cap_byte_d;
   logic                   cap_valid_q, cap_valid_d;
   logic                   b_free, a_move, in_ready, accept;
   logic [DATA_W-1:0]      swapped_data;

   axis_eth_mac_swap u_swap (
      .clk          (clk),
      .rst          (rst),
      .swap_mode    (swap_q),
      .a_move       (a_move),
      .a_idx        (a_idx_q),
      .a_last       (a_q.last),
      .a_data       (a_q.data),
      .next_keep_lo (input_axis.tkeep[SWAP_KEEP_W-1:0]),
      .next_data_lo (input_axis.tdata[8*SWAP_KEEP_W-1:0]),
      .out_data     (swapped_data)
   );

   // A beat 0 that is not the last waits for beat 1 so the swap can see the source MAC tail.
   always_comb begin
      b_free   = !b_valid_q || output_axis.tready;
      a_move   = a_valid_q && b_free && (input_axis.tvalid || a_q.last || a_idx_q == BEAT_REST);
      in_ready = rdy_q && (!a_valid_q || a_move);
      accept   = input_axis.tvalid && in_ready;
      in_idx   = (cap_idx_q >= 4'd2) ? BEAT_REST : beat_idx_e'(cap_idx_q[1:0]);

      in_beat.data = input_axis.tdata;
      in_beat.keep = input_axis.tkeep;
      in_beat.last = input_axis.tlast;
      in_beat.user = input_axis.tuser;

      rdy_d     = 1'b1;
      a_d       = a_q;
      a_valid_d = a_valid_q && !a_move;
      a_idx_d   = a_idx_q;
      if (accept) begin
         a_d       = in_beat;
         a_valid_d = 1'b1;
         a_idx_d   = in_idx;
      end

      b_d       = b_q;
      b_valid_d = b_valid_q && !output_axis.tready;
      if (a_move) begin
         b_d       = a_q;
         b_d.data  = swapped_data;
         b_valid_d = 1'b1;
      end

      cap_idx_d = cap_idx_q;
      swap_d    = swap_q;
      if (accept) begin
         if (input_axis.tlast) begin
            cap_idx_d = 4'd0;
         end else if (cap_idx_q != 4'hF) begin
            cap_idx_d = cap_idx_q + 4'd1;
         end
         if (in_idx == BEAT_FIRST) begin
            swap_d = swap_enable;
         end
      end

      frame_cnt_d = frame_cnt_q;
      err_cnt_d   = err_cnt_q;
      cap_byte_d  = cap_byte_q;
      cap_valid_d = cap_valid_q;
      if (stat_clear) begin
         frame_cnt_d = '0;
         err_cnt_d   = '0;
         cap_byte_d  = 8'h00;
         cap_valid_d = 1'b0;
      end else if (accept) begin
         if (input_axis.tlast) begin
            frame_cnt_d = frame_cnt_q + COUNT_WIDTH'(1);
            if (input_axis.tuser) begin
               err_cnt_d = err_cnt_q + COUNT_WIDTH'(1);
            end
         end
         if (cap_idx_q == CAP_BEAT && input_axis.tkeep[CAP_LANE]) begin
            cap_byte_d  = input_axis.tdata[8*CAP_LANE +: 8];
            cap_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q         <= '0;
         a_valid_q   <= 1'b0;
         a_idx_q     <= BEAT_FIRST;
         b_q         <= '0;
         b_valid_q   <= 1'b0;
         cap_idx_q   <= 4'd0;
         swap_q      <= SWAP_DEFAULT;
         rdy_q       <= 1'b0;
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
         cap_byte_q  <= 8'h00;
         cap_valid_q <= 1'b0;
      end else begin
         a_q         <= a_d;
         a_valid_q   <= a_valid_d;
         a_idx_q     <= a_idx_d;
         b_q         <= b_d;
         b_valid_q   <= b_valid_d;
         cap_idx_q   <= cap_idx_d;
         swap_q      <= swap_d;
         rdy_q       <= rdy_d;
         frame_cnt_q <= frame_cnt_d;
         err_cnt_q   <= err_cnt_d;
         cap_byte_q  <= cap_byte_d;
         cap_valid_q <= cap_valid_d;
      end
   end

   assign input_axis.tready  = in_ready;
   assign output_axis.tvalid = b_valid_q;
   assign output_axis.tdata  = b_q.data;
   assign output_axis.tkeep  = b_q.keep;
   assign output_axis.tlast  = b_q.last;
   assign output_axis.tuser  = b_q.user;
   assign stat_frame_count   = frame_cnt_q;
   assign stat_error_count   = err_cnt_q;
   assign stat_capture_byte  = cap_byte_q;
   assign stat_capture_valid = cap_valid_q;

endmodule

// File: tb/tb_axis_eth_loopback_64.sv
// Bench for axis_eth_loopback_64: table of frames with per-frame stat expectations, a byte-level
// MAC-swap model feeding an output scoreboard, plus throughput, clear, random and reset sequences.
module tb_axis_eth_loopback_64;
   import axis_eth_pkg::*;

   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          swap_enable = 1'b0;
   logic          stat_clear = 1'b0;
   logic [CW-1:0] frame_count, error_count;
   logic [7:0]    cap_byte;
   logic          cap_valid;

   axis_eth_if in_if();
   axis_eth_if out_if();

   axis_eth_loopback_64 #(.COUNT_WIDTH(CW), .CAPTURE_OFFSET(14), .SWAP_DEFAULT(1'b1)) dut (
      .clk                (clk),
      .rst                (rst),
      .swap_enable        (swap_enable),
      .stat_clear         (stat_clear),
      .input_axis         (in_if),
      .output_axis        (out_if),
      .stat_frame_count   (frame_count),
      .stat_error_count   (error_count),
      .stat_capture_byte  (cap_byte),
      .stat_capture_valid (cap_valid)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic        user;
   } exp_beat_t;

   typedef struct {
      int         len;
      bit         swap_en;
      bit         user;
      logic [7:0] cap_val;
      bit         rand_mac;
      int         exp_frames;
      int         exp_errors;
      logic [7:0] exp_cap;
      bit         exp_cap_valid;
   } vec_t;

   exp_beat_t  exp_q[$];
   vec_t       vecs[12];
   logic [7:0] frame_bytes [0:127];
   int         checks = 0;
   int         failures = 0;
   int         cycle = 0;
   bit         bp_mode = 1'b0;
   bit         gap_mode = 1'b0;
   int         model_frames = 0;
   int         model_errors = 0;
   logic [7:0] model_cap = 8'h00;
   bit         model_cap_valid = 1'b0;

   exp_beat_t  cur, held, e;
   bit         held_valid = 1'b0;
   bit         burst_arm = 1'b0;
   int         out_beats = 0;
   int         first_xfer_cycle = 0;
   int         last_xfer_cycle = 0;

   always @(posedge clk) cycle <= cycle + 1;

   initial begin
      out_if.tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_if.tready = bp_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   // Output monitor: scoreboard pop on each transfer, hold check on each stalled beat.
   always @(negedge clk) begin
      cur = {out_if.tdata, out_if.tkeep, out_if.tlast, out_if.tuser};
      if (rst) begin
         held_valid = 1'b0;
      end else begin
         if (held_valid) begin
            checks++;
            if (!out_if.tvalid || cur != held) begin
               failures++;
               $display("[TB] FAIL stall_hold got valid=%b beat=%h required valid=1 beat=%h", out_if.tvalid, cur, held);
            end
         end
         held_valid = 1'b0;
         if (out_if.tvalid && !out_if.tready) begin
            held_valid = 1'b1;
            held = cur;
         end
         if (out_if.tvalid && out_if.tready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("[TB] FAIL out_unexpected got data=%h keep=%h last=%b user=%b required no beat", out_if.tdata, out_if.tkeep, out_if.tlast, out_if.tuser);
            end else begin
               e = exp_q.pop_front();
               if (cur !== e) begin
                  failures++;
                  $display("[TB] FAIL out_beat got data=%h keep=%h last=%b user=%b required data=%h keep=%h last=%b user=%b", out_if.tdata, out_if.tkeep, out_if.tlast, out_if.tuser, e.data, e.keep, e.last, e.user);
               end
            end
            out_beats++;
            if (burst_arm) begin
               first_xfer_cycle = cycle;
               burst_arm = 1'b0;
            end
            last_xfer_cycle = cycle;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("[TB] FAIL %s got=%h required=%h", name, got, want);
      end
   endtask

   task automatic checkResetState();
      checkOutput("rst_out_tvalid", 64'(out_if.tvalid), 64'd0);
      checkOutput("rst_out_tdata", out_if.tdata, 64'd0);
      checkOutput("rst_out_tkeep", 64'(out_if.tkeep), 64'd0);
      checkOutput("rst_out_tlast", 64'(out_if.tlast), 64'd0);
      checkOutput("rst_out_tuser", 64'(out_if.tuser), 64'd0);
      checkOutput("rst_frame_count", 64'(frame_count), 64'd0);
      checkOutput("rst_error_count", 64'(error_count), 64'd0);
      checkOutput("rst_capture_byte", 64'(cap_byte), 64'd0);
      checkOutput("rst_capture_valid", 64'(cap_valid), 64'd0);
      checkOutput("rst_in_tready", 64'(in_if.tready), 64'd0);
   endtask

   task automatic buildFrame(input int len, input logic [7:0] cap_val, input bit rand_mac);
      logic [7:0] mac [0:11];
      mac = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};
      for (int i = 0; i < 128; i++) frame_bytes[i] = 8'($urandom);
      for (int i = 0; i < 12; i++) frame_bytes[i] = rand_mac ? 8'($urandom) : mac[i];
      frame_bytes[12] = 8'h08;
      frame_bytes[13] = 8'h00;
      frame_bytes[14] = cap_val;
      for (int i = len; i < 128; i++) frame_bytes[i] = 8'h00;
   endtask

   // Drives frame_bytes as one frame (or its first max_beats beats) and queues the expected output.
   task automatic applyStimulus(input int len, input bit swap_en, input bit user, input int max_beats, input bit clr_on_last);
      logic [7:0] eb [0:127];
      exp_beat_t  xb;
      int         nbeats;
      int         waited;
      bit         rdy;
      nbeats = (len + 7) / 8;
      for (int i = 0; i < 128; i++) eb[i] = frame_bytes[i];
      if (swap_en && len >= 12) begin
         for (int i = 0; i < 6; i++) begin
            eb[i]     = frame_bytes[i + 6];
            eb[i + 6] = frame_bytes[i];
         end
      end
      for (int b = 0; b < nbeats; b++) begin
         for (int l = 0; l < 8; l++) begin
            xb.data[8*l +: 8] = eb[b*8 + l];
            xb.keep[l]        = (b*8 + l) < len;
         end
         xb.last = (b == nbeats - 1);
         xb.user = xb.last && user;
         exp_q.push_back(xb);
      end
      for (int b = 0; b < nbeats && b < max_beats; b++) begin
         while (gap_mode && $urandom_range(0, 2) == 0) begin
            in_if.tvalid = 1'b0;
            @(posedge clk);
            #1;
         end
         for (int l = 0; l < 8; l++) begin
            in_if.tdata[8*l +: 8] = frame_bytes[b*8 + l];
            in_if.tkeep[l]        = (b*8 + l) < len;
         end
         in_if.tlast  = (b == nbeats - 1);
         in_if.tuser  = (b == nbeats - 1) && user;
         in_if.tvalid = 1'b1;
         swap_enable  = (b == 0) ? swap_en : 1'($urandom_range(0, 1));
         stat_clear   = (b == nbeats - 1) && clr_on_last;
         waited = 0;
         do begin
            @(negedge clk);
            rdy = in_if.tready;
            @(posedge clk);
            #1;
            waited++;
         end while (!rdy && waited < 1000);
         stat_clear = 1'b0;
         if (!rdy) begin
            checks++;
            failures++;
            $display("[TB] FAIL in_accept_timeout got tready=0 for %0d cycles required tready=1", waited);
         end
      end
      in_if.tvalid = 1'b0;
      if (nbeats <= max_beats) begin
         if (clr_on_last) begin
            model_frames    = 0;
            model_errors    = 0;
            model_cap       = 8'h00;
            model_cap_valid = 1'b0;
         end else begin
            model_frames++;
            if (user) model_errors++;
            if (len > 14) begin
               model_cap       = frame_bytes[14];
               model_cap_valid = 1'b1;
            end
         end
      end
   endtask

   task automatic waitDrain(input string what);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_if.tvalid) && n < 5000) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (exp_q.size() != 0 || out_if.tvalid) begin
         failures++;
         $display("[TB] FAIL drain_%s got pending=%0d tvalid=%b required pending=0 tvalid=0", what, exp_q.size(), out_if.tvalid);
      end
   endtask

   initial begin
      #2_000_000;
      failures++;
      $display("[TB] FAIL watchdog got time=%0t required completion", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int t0;
      int t1;
      vecs[0]  = '{64, 1'b1, 1'b0, 8'hA5, 1'b0,  1, 0, 8'hA5, 1'b1};
      vecs[1]  = '{64, 1'b0, 1'b0, 8'h3C, 1'b0,  2, 0, 8'h3C, 1'b1};
      vecs[2]  = '{ 8, 1'b1, 1'b0, 8'h00, 1'b0,  3, 0, 8'h3C, 1'b1};
      vecs[3]  = '{10, 1'b1, 1'b0, 8'h00, 1'b0,  4, 0, 8'h3C, 1'b1};
      vecs[4]  = '{60, 1'b1, 1'b0, 8'h11, 1'b0,  5, 0, 8'h11, 1'b1};
      vecs[5]  = '{60, 1'b1, 1'b1, 8'h22, 1'b0,  6, 1, 8'h22, 1'b1};
      vecs[6]  = '{60, 1'b0, 1'b0, 8'h33, 1'b0,  7, 1, 8'h33, 1'b1};
      vecs[7]  = '{64, 1'b1, 1'b0, 8'hA5, 1'b1,  8, 1, 8'hA5, 1'b1};
      vecs[8]  = '{12, 1'b1, 1'b0, 8'h00, 1'b1,  9, 1, 8'hA5, 1'b1};
      vecs[9]  = '{15, 1'b1, 1'b0, 8'h5A, 1'b1, 10, 1, 8'h5A, 1'b1};
      vecs[10] = '{14, 1'b1, 1'b0, 8'h77, 1'b1, 11, 1, 8'h5A, 1'b1};
      vecs[11] = '{ 9, 1'b1, 1'b1, 8'h00, 1'b1, 12, 2, 8'h5A, 1'b1};

      in_if.tvalid = 1'b0;
      in_if.tdata  = '0;
      in_if.tkeep  = '0;
      in_if.tlast  = 1'b0;
      in_if.tuser  = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      checkResetState();
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("ready_after_reset", 64'(in_if.tready), 64'd1);

      for (int v = 0; v < 12; v++) begin
         buildFrame(vecs[v].len, vecs[v].cap_val, vecs[v].rand_mac);
         applyStimulus(vecs[v].len, vecs[v].swap_en, vecs[v].user, 1000, 1'b0);
         waitDrain("table");
         checkOutput($sformatf("v%0d_frame_count", v), 64'(frame_count), 64'(vecs[v].exp_frames));
         checkOutput($sformatf("v%0d_error_count", v), 64'(error_count), 64'(vecs[v].exp_errors));
         checkOutput($sformatf("v%0d_capture_byte", v), 64'(cap_byte), 64'(vecs[v].exp_cap));
         checkOutput($sformatf("v%0d_capture_valid", v), 64'(cap_valid), 64'(vecs[v].exp_cap_valid));
      end

      t0 = out_beats;
      burst_arm = 1'b1;
      t1 = cycle;
      for (int f = 0; f < 4; f++) begin
         buildFrame(64, 8'hC3, 1'b1);
         applyStimulus(64, 1'b1, 1'b0, 1000, 1'b0);
      end
      checkOutput("burst_in_cycles", 64'(cycle - t1), 64'd32);
      waitDrain("burst");
      checkOutput("burst_out_beats", 64'(out_beats - t0), 64'd32);
      checkOutput("burst_out_span", 64'(last_xfer_cycle - first_xfer_cycle + 1), 64'd32);

      buildFrame(8, 8'h00, 1'b1);
      applyStimulus(8, 1'b1, 1'b1, 1000, 1'b1);
      waitDrain("clear");
      checkOutput("clear_frame_count", 64'(frame_count), 64'd0);
      checkOutput("clear_error_count", 64'(error_count), 64'd0);
      checkOutput("clear_capture_byte", 64'(cap_byte), 64'd0);
      checkOutput("clear_capture_valid", 64'(cap_valid), 64'd0);

      bp_mode  = 1'b1;
      gap_mode = 1'b1;
      for (int f = 0; f < 1000; f++) begin
         int len;
         len = $urandom_range(1, 80);
         buildFrame(len, 8'($urandom), 1'b1);
         applyStimulus(len, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1000, 1'b0);
      end
      waitDrain("random");
      bp_mode  = 1'b0;
      gap_mode = 1'b0;
      checkOutput("rand_frame_count", 64'(frame_count), 64'(model_frames));
      checkOutput("rand_error_count", 64'(error_count), 64'(model_errors));
      checkOutput("rand_capture_byte", 64'(cap_byte), 64'(model_cap));
      checkOutput("rand_capture_valid", 64'(cap_valid), 64'(model_cap_valid));

      @(posedge clk);
      #1;
      buildFrame(64, 8'h99, 1'b1);
      applyStimulus(64, 1'b1, 1'b0, 3, 1'b0);
      #2;
      rst = 1'b1;
      exp_q.delete();
      model_frames    = 0;
      model_errors    = 0;
      model_cap       = 8'h00;
      model_cap_valid = 1'b0;
      #1;
      checkResetState();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("ready_after_midframe_reset", 64'(in_if.tready), 64'd1);
      buildFrame(64, 8'h6E, 1'b0);
      applyStimulus(64, 1'b1, 1'b0, 1000, 1'b0);
      waitDrain("post_reset");
      checkOutput("post_reset_frame_count", 64'(frame_count), 64'd1);
      checkOutput("post_reset_error_count", 64'(error_count), 64'd0);
      checkOutput("post_reset_capture_byte", 64'(cap_byte), 64'h6E);

      repeat (5) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
